// File: rtl/ser_field_deser.sv
// Framed serial deserialiser: start, 9 data bits LSB first, parity, stop.
// Splits good words into 2/3/4-bit fields and counts errored frames.
module ser_field_deser #(
    parameter bit PARITY_ODD = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_en,
    input  logic             ser_in,
    input  logic             err_clr,
    output logic [1:0]       data_in1,
    output logic [2:0]       data_in2,
    output logic [3:0]       data_in3,
    output logic             check,
    output logic             par_err,
    output logic             frm_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA  = 3'd1,
        S_PAR   = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [8:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [1:0]       f1_q, f1_d;
    logic [2:0]       f2_q, f2_d;
    logic [3:0]       f3_q, f3_d;
    logic             check_q, check_d;
    logic             par_err_q, par_err_d;
    logic             frm_err_q, frm_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_inc_s;

    function automatic logic calc_parity(input logic [8:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Next-state, datapath and strobe logic; nothing moves without ser_en.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        f1_d      = f1_q;
        f2_d      = f2_q;
        f3_d      = f3_q;
        check_d   = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        err_inc_s = 1'b0;
        if (ser_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!ser_in) begin
                        state_d  = S_DATA;
                        bitcnt_d = 4'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    // LSB-first shift: after nine samples d[0] sits in bit 0.
                    shift_d = {ser_in, shift_q[8:1]};
                    if (bitcnt_q == 4'd8) begin
                        state_d = S_PAR;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
                S_PAR: begin
                    par_d   = ser_in;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (ser_in) begin
                        state_d = S_IDLE;
                        if (calc_parity(shift_q, PARITY_ODD) == par_q) begin
                            f1_d    = shift_q[1:0];
                            f2_d    = shift_q[4:2];
                            f3_d    = shift_q[8:5];
                            check_d = 1'b1;
                        end else begin
                            par_err_d = 1'b1;
                            err_inc_s = 1'b1;
                        end
                    end else begin
                        frm_err_d = 1'b1;
                        err_inc_s = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (ser_in) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BREAK;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Saturating error counter; clear wins over a same-cycle increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = {CNT_W{1'b0}};
        end else if (err_inc_s && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= 4'd0;
            shift_q   <= 9'd0;
            par_q     <= 1'b0;
            f1_q      <= 2'd0;
            f2_q      <= 3'd0;
            f3_q      <= 4'd0;
            check_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            err_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            f1_q      <= f1_d;
            f2_q      <= f2_d;
            f3_q      <= f3_d;
            check_q   <= check_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign data_in1 = f1_q;
    assign data_in2 = f2_q;
    assign data_in3 = f3_q;
    assign check    = check_q;
    assign par_err  = par_err_q;
    assign frm_err  = frm_err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ser_field_deser.sv
// Directed bench for ser_field_deser (CNT_W = 2, even parity).
// Inputs change #1 after posedge; outputs are read at that same point.
module tb_ser_field_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_en = 1'b0;
    logic       ser_in = 1'b1;
    logic       err_clr = 1'b0;
    logic [1:0] data_in1;
    logic [2:0] data_in2;
    logic [3:0] data_in3;
    logic       check;
    logic       par_err;
    logic       frm_err;
    logic [1:0] err_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    ser_field_deser #(.PARITY_ODD(1'b0), .CNT_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ser_en   (ser_en),
        .ser_in   (ser_in),
        .err_clr  (err_clr),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .data_in3 (data_in3),
        .check    (check),
        .par_err  (par_err),
        .frm_err  (frm_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap idle cycles (ser_en low, line glitching) then one sampled bit.
    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            ser_en = 1'b0;
            ser_in = 1'($urandom_range(1, 0));
            tick();
        end
        ser_en = 1'b1;
        ser_in = b;
        tick();
        ser_en = 1'b0;
        ser_in = 1'b1;
    endtask

    task automatic chk_strobes(input string tag, input logic c, input logic p, input logic f);
        check_eq({tag, ".check"}, 32'(check), 32'(c));
        check_eq({tag, ".par_err"}, 32'(par_err), 32'(p));
        check_eq({tag, ".frm_err"}, 32'(frm_err), 32'(f));
    endtask

    task automatic chk_fields(input string tag, input logic [1:0] a, input logic [2:0] b, input logic [3:0] c);
        check_eq({tag, ".f1"}, 32'(data_in1), 32'(a));
        check_eq({tag, ".f2"}, 32'(data_in2), 32'(b));
        check_eq({tag, ".f3"}, 32'(data_in3), 32'(c));
    endtask

    // Sends a whole frame; returns just after the edge that sampled stop.
    task automatic send_frame(input string tag, input logic [8:0] d, input logic par,
                              input logic stop, input int gap, input logic clr_at_stop);
        send_bit(1'b0, gap);
        for (int i = 0; i < 9; i++) send_bit(d[i], gap);
        send_bit(par, gap);
        chk_strobes({tag, ".pre"}, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < gap; g++) begin
            ser_en = 1'b0;
            ser_in = 1'($urandom_range(1, 0));
            tick();
        end
        ser_en  = 1'b1;
        ser_in  = stop;
        err_clr = clr_at_stop;
        tick();
        ser_en  = 1'b0;
        ser_in  = 1'b1;
        err_clr = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk_strobes("reset", 1'b0, 1'b0, 1'b0);
        chk_fields("reset", 2'd0, 3'd0, 4'd0);
        check_eq("reset.err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Good frame, back-to-back strobes: check at start+12.
        send_frame("good", 9'h14D, 1'b1, 1'b1, 0, 1'b0);
        chk_strobes("good", 1'b1, 1'b0, 1'b0);
        chk_fields("good", 2'b01, 3'b011, 4'b1010);
        check_eq("good.err_cnt", 32'(err_cnt), 32'd0);
        tick();
        chk_strobes("good.after", 1'b0, 1'b0, 1'b0);

        // Parity error: fields hold.
        send_frame("perr", 9'h14D, 1'b0, 1'b1, 0, 1'b0);
        chk_strobes("perr", 1'b0, 1'b1, 1'b0);
        chk_fields("perr", 2'b01, 3'b011, 4'b1010);
        check_eq("perr.err_cnt", 32'(err_cnt), 32'd1);
        tick();
        chk_strobes("perr.after", 1'b0, 1'b0, 1'b0);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("clr.err_cnt", 32'(err_cnt), 32'd0);

        // Framing error with bad parity too: framing wins, then a line break.
        send_frame("ferr", 9'h14D, 1'b0, 1'b0, 0, 1'b0);
        chk_strobes("ferr", 1'b0, 1'b0, 1'b1);
        check_eq("ferr.err_cnt", 32'(err_cnt), 32'd1);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        chk_strobes("break", 1'b0, 1'b0, 1'b0);
        check_eq("break.err_cnt", 32'(err_cnt), 32'd1);
        send_frame("recov", 9'h1FF, 1'b1, 1'b1, 0, 1'b0);
        chk_strobes("recov", 1'b1, 1'b0, 1'b0);
        chk_fields("recov", 2'd3, 3'd7, 4'd15);
        check_eq("recov.err_cnt", 32'(err_cnt), 32'd1);

        // Sparse strobe: ser_en every 4th cycle, glitches in between.
        send_frame("sparse", 9'h14D, 1'b1, 1'b1, 3, 1'b0);
        chk_strobes("sparse", 1'b1, 1'b0, 1'b0);
        chk_fields("sparse", 2'b01, 3'b011, 4'b1010);
        tick();
        chk_strobes("sparse.after", 1'b0, 1'b0, 1'b0);

        // Reset after 5 data bits.
        send_bit(1'b0, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        rst = 1'b1;
        tick();
        chk_strobes("midrst", 1'b0, 1'b0, 1'b0);
        chk_fields("midrst", 2'd0, 3'd0, 4'd0);
        check_eq("midrst.err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk_strobes("midrst.after", 1'b0, 1'b0, 1'b0);
        send_frame("postrst", 9'h1FF, 1'b1, 1'b1, 0, 1'b0);
        chk_strobes("postrst", 1'b1, 1'b0, 1'b0);
        chk_fields("postrst", 2'd3, 3'd7, 4'd15);

        // Saturation at 3 with CNT_W = 2, then clear beats increment.
        for (int k = 1; k <= 5; k++) begin
            send_frame("sat", 9'h0A5, 1'b1, 1'b1, 0, 1'b0);
            chk_strobes("sat", 1'b0, 1'b1, 1'b0);
            check_eq("sat.err_cnt", 32'(err_cnt), (k < 3) ? 32'(k) : 32'd3);
        end
        chk_fields("sat", 2'd3, 3'd7, 4'd15);
        send_frame("satclr", 9'h0A5, 1'b1, 1'b1, 0, 1'b1);
        chk_strobes("satclr", 1'b0, 1'b1, 1'b0);
        check_eq("satclr.err_cnt", 32'(err_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ser_field_deser.md
# ser_field_deser

Upstream front-end of the lint datapath. It deserialises a framed 1-bit serial stream into a 9-bit word and splits the word into the 2-, 3- and 4-bit fields consumed by the downstream field-register stage. The `check` qualifier pulses for exactly one cycle per valid frame. Start, parity and stop bits are checked, and a saturating error counter is kept for debug readout.

## Interface
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity over the 9 data bits.
- `CNT_W`, default 8: width of the error counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ser_en`  in  1  bit-sample strobe. The serial line is sampled only in cycles where this is 1.
- `ser_in`  in  1  serial line. Idles high.
- `err_clr`  in  1  synchronous clear of `err_cnt`.
- `data_in1`  out  2  field 1 = d[1:0].
- `data_in2`  out  3  field 2 = d[4:2].
- `data_in3`  out  4  field 3 = d[8:5].
- `check`  out  1  one-cycle strobe: new fields are valid.
- `par_err`  out  1  one-cycle strobe: parity mismatch.
- `frm_err`  out  1  one-cycle strobe: stop bit was 0.
- `err_cnt`  out  CNT_W  saturating count of errored frames.

## Operation
- Frame, in sample order (samples taken only when `ser_en` = 1):
  - start bit (0)
  - d[0] .. d[8], LSB first
  - parity bit
  - stop bit (1)
- Expected parity bit = `^d` XOR `PARITY_ODD`.
- States:
  - IDLE: a sampled 0 goes to DATA and clears the bit counter. A sampled 1 stays in IDLE.
  - DATA: shift the sampled bit into `d[bitcnt]`. After bit 8 (bitcnt = 8), go to PAR.
  - PAR: capture the parity bit, go to STOP.
  - STOP:
    - Sampled 1 and parity good: update all three fields, pulse `check`, go to IDLE.
    - Sampled 1 and parity bad: pulse `par_err`, increment `err_cnt`, leave fields unchanged, go to IDLE.
    - Sampled 0: pulse `frm_err` only (framing takes priority over parity), increment `err_cnt`, leave fields unchanged, go to BREAK.
  - BREAK: wait for a sampled 1, then go to IDLE. Further sampled 0s are ignored and counted no further.
- Cycles with `ser_en` = 0 never change state, the shift register or the bit counter.
- Fields hold their last good value indefinitely. They change only in the same cycle that `check` pulses.
- `err_cnt`:
  - +1 per errored frame.
  - Saturates at all-ones and never wraps.
  - `err_clr` = 1 forces it to 0. This has priority over a same-cycle increment, so the result is 0.
- Reset (`rst` = 1 at a clock edge) at any point, including mid-frame:
  - state goes to IDLE, bit counter to 0, shift register to 0;
  - all fields = 0;
  - `check`, `par_err`, `frm_err` = 0;
  - `err_cnt` = 0.
  - A partially received frame is discarded without any error strobe.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- The `check`/`par_err`/`frm_err` strobe and the field update occur in the cycle after the clock edge that samples the stop bit. Each strobe is high for exactly one cycle.
- At most one of `check`, `par_err`, `frm_err` is high in any cycle.
- Minimum frame length is 12 strobes. Back-to-back frames are legal: a start bit may be sampled on the very next strobe after the stop bit.
- With `ser_en` tied to 1, a frame starting at cycle N produces its strobe at cycle N+12.
- `err_cnt` updates in the same cycle as the error strobe.

## Test plan
- Good frame, `ser_en` = 1, even parity: send start 0, d = 9'h14D LSB first, parity 1, stop 1. Required: `check` = 1 for one cycle at start+12; `data_in1` = 2'b01, `data_in2` = 3'b011, `data_in3` = 4'b1010; `err_cnt` = 0.
- Parity error: same frame with parity 0. Required: `par_err` pulses once, `check` stays 0, fields keep their previous values, `err_cnt` = 1.
- Framing error then recovery: send stop 0, then the line held at 0 for 5 strobes, then 1, then a good frame with d = 9'h1FF and parity 1. Required: `frm_err` pulses once with no `par_err`; `err_cnt` = 1; the next `check` gives fields 3, 7, 15.
- Sparse strobe: `ser_en` high every 4th cycle while sending frame d = 9'h14D. Required: result identical to scenario 1, with the strobe 1 cycle after the 12th `ser_en` pulse. `ser_in` glitches while `ser_en` = 0 are ignored.
- Reset mid-frame: assert `rst` after 5 data bits, then send a complete good frame. Required: all outputs read 0 during and right after reset, no error strobe, the good frame then decodes correctly.
- Counter saturation and clear: with `CNT_W` = 2, send 5 parity-error frames. Required: `err_cnt` = 3 after the 3rd frame and stays 3. Asserting `err_clr` in the same cycle as the 6th `par_err` strobe gives `err_cnt` = 0.
